frame_queue_reader: RTL and testbench
=====================================

FRAME_QUEUE_READER -- requirements
Module: FrameQueueReader

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 640, pixels per row.
REQ-002 SHALL have parameter FRAME_HEIGHT, default 480, rows per frame.
REQ-003 SHALL have parameter BURST_WORDS, default 32, 16-bit words per memory burst; FRAME_WIDTH must be a multiple of BURST_WORDS.
REQ-004 SHALL have parameter BASE_ADDR, default 0, word address of pixel (0,0).
REQ-005 SHALL have port MemClk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port nRST, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port queue_data, input, 17, FIFO read data, valid one cycle after queue_rd_en.
REQ-008 SHALL have port queue_empty, input, 1, FIFO empty flag.
REQ-009 SHALL have port queue_rd_en, output, 1, FIFO read strobe.
REQ-010 SHALL have port mem_ready, input, 1, memory controller initialised.
REQ-011 SHALL have port wr_req, output, 1, burst write request.
REQ-012 SHALL have port wr_grant, input, 1, one-cycle burst acceptance.
REQ-013 SHALL have port wr_addr, output, 21, burst start word address.
REQ-014 SHALL have port wr_data, output, 16, burst data word.
REQ-015 SHALL have port wr_data_valid, output, 1, qualifies wr_data.
REQ-016 SHALL have port frame_done, output, 1, one-cycle pulse on a correct frame end.
REQ-017 SHALL have port frame_error, output, 1, one-cycle pulse on a protocol violation.

Function
REQ-018 SHALL decode words: 0x10000 frame start (FS), 0x10001 row start (RS), 0x1FFFF frame end (FE), bit16=0 pixel (bits 15:0); any other bit16=1 word is a violation.
REQ-019 SHALL keep at most one read outstanding: assert queue_rd_en for one cycle only when !queue_empty and the state consumes, then decode the word on the next cycle.
REQ-020 SHALL implement states IDLE, WAIT_FS, WAIT_RS, FILL, REQUEST, BURST, FRAME_END.
REQ-021 IDLE -> WAIT_FS when mem_ready=1; no reads in IDLE.
REQ-022 WAIT_FS SHALL discard all words until FS, then clear row/col counters -> WAIT_RS.
REQ-023 WAIT_RS: RS -> FILL with col=0; FE -> FRAME_END; pixel or FS is a violation.
REQ-024 FILL SHALL write each pixel to buffer index col mod BURST_WORDS and increment col; when a burst's worth is buffered -> REQUEST.
REQ-025 REQUEST SHALL hold wr_req=1 with wr_addr = BASE_ADDR + row*FRAME_WIDTH + (col - BURST_WORDS) until wr_grant, then -> BURST; no reads in REQUEST or BURST.
REQ-026 BURST SHALL drive BURST_WORDS consecutive cycles of wr_data_valid=1 in buffer order, then -> FILL if col<FRAME_WIDTH, else row+1 and -> WAIT_RS.
REQ-027 FE in WAIT_RS with row==FRAME_HEIGHT SHALL pulse frame_done; otherwise pulse frame_error; both -> WAIT_FS.
REQ-028 Violations: FS while in a frame pulses frame_error and restarts (counters cleared, -> WAIT_RS); RS or FE in FILL pulses frame_error, discards the partial burst, then processes the marker as in WAIT_RS with row incremented; pixels beyond FRAME_WIDTH are impossible by construction; unknown marker pulses frame_error -> WAIT_FS.
REQ-029 Address arithmetic SHALL be 21-bit unsigned, wrapping modulo 2^21.
REQ-030 mem_ready falling SHALL be honoured only in WAIT_FS (-> IDLE); an active frame completes.

Reset
REQ-031 On nRST=0 all outputs SHALL be 0, counters cleared, state IDLE, regardless of mid-burst or mid-read; an in-flight read word is lost.
REQ-032 Release of nRST SHALL take effect on the first MemClk rising edge.

Structure
REQ-033 Marker constants and the state enum SHALL live in the shared package frame_queue_pkg, also used by the camera-side writer.
REQ-034 The buffer SHALL be a sub-module BurstBuffer (BURST_WORDS x 16, one write port, one registered read port).

Verification (FRAME_WIDTH=8, FRAME_HEIGHT=2, BURST_WORDS=4, BASE_ADDR=0x100)
REQ-035 FS, RS, pixels 0..7, RS, pixels 8..15, FE -> 4 bursts at 0x100/0x104/0x108/0x10C, data 0..15 in order, one frame_done, no frame_error.
REQ-036 Random queue_empty gaps and wr_grant delays of 0-10 cycles on the REQ-035 stream -> identical bursts, and wr_req held steady until wr_grant.
REQ-037 FS, RS, 5 pixels, RS -> frame_error pulse, one burst at 0x100 only, next row bursts at 0x108.
REQ-038 FS, RS, 8 pixels, FE (row=1) -> frame_error, no frame_done, FSM back in WAIT_FS.
REQ-039 Junk pixels and 0x10005 before FS -> all discarded, no writes, no error until after FS.
REQ-040 nRST asserted during the second beat of BURST -> all outputs 0 immediately; after release with mem_ready=1 a new frame is captured correctly.

Source files
------------

// File: rtl/frame_queue_pkg.sv
// Shared definitions for the frame queue between the camera-side writer and
// the memory-side reader.
//   MARK_FS / MARK_RS / MARK_FE : 17-bit in-band marker words (bit 16 set)
//   fqr_state_t                 : reader FSM states
//   word_kind_t / classify()    : decode of one queue word
package frame_queue_pkg;

    localparam logic [16:0] MARK_FS = 17'h10000;
    localparam logic [16:0] MARK_RS = 17'h10001;
    localparam logic [16:0] MARK_FE = 17'h1FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FS,
        ST_WAIT_RS,
        ST_FILL,
        ST_REQUEST,
        ST_BURST,
        ST_FRAME_END
    } fqr_state_t;

    typedef enum logic [2:0] {
        WK_PIXEL,
        WK_FS,
        WK_RS,
        WK_FE,
        WK_BAD
    } word_kind_t;

    // Any word with bit 16 clear is a pixel; bit 16 set must be a known marker.
    function automatic word_kind_t classify(input logic [16:0] w);
        if (!w[16])            return WK_PIXEL;
        else if (w == MARK_FS) return WK_FS;
        else if (w == MARK_RS) return WK_RS;
        else if (w == MARK_FE) return WK_FE;
        return WK_BAD;
    endfunction

endpackage

// File: rtl/frame_queue_reader_burst_buffer.sv
// One-burst staging buffer: DEPTH x 16 bit, one write port, one read port with
// a registered output (read data appears the cycle after raddr is presented).
//   clk          : clock
//   we/waddr/wdata : write port
//   raddr/rdata  : registered read port
module frame_queue_reader_burst_buffer #(
    parameter int DEPTH = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [15:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [15:0]      rdata
);

    logic [15:0] mem_reg [DEPTH];

    // No reset on the array or the read register so the tools can map this
    // onto block RAM; the consumer masks rdata outside of a burst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
        rdata <= mem_reg[raddr];
    end

endmodule

// File: rtl/frame_queue_reader.sv
// Drains a 17-bit frame queue (pixels plus FS/RS/FE markers), stages pixels in
// a one-burst buffer and writes them to memory as fixed-length bursts.
//   MemClk, nRST        : clock, asynchronous active-low reset
//   queue_data/empty/rd_en : FIFO read side, data valid the cycle after rd_en
//   mem_ready           : memory controller is initialised
//   wr_req/grant/addr   : burst request handshake, addr held until grant
//   wr_data/_valid      : burst data beats, in buffer order
//   frame_done/error    : one-cycle status pulses
module frame_queue_reader
    import frame_queue_pkg::*;
#(
    parameter int          FRAME_WIDTH  = 640,
    parameter int          FRAME_HEIGHT = 480,
    parameter int          BURST_WORDS  = 32,
    parameter logic [20:0] BASE_ADDR    = 21'd0
) (
    input  logic        MemClk,
    input  logic        nRST,
    input  logic [16:0] queue_data,
    input  logic        queue_empty,
    output logic        queue_rd_en,
    input  logic        mem_ready,
    output logic        wr_req,
    input  logic        wr_grant,
    output logic [20:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        wr_data_valid,
    output logic        frame_done,
    output logic        frame_error
);

    localparam int              IDX_W    = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
    localparam logic [20:0]     FW       = 21'(FRAME_WIDTH);
    localparam logic [20:0]     FH       = 21'(FRAME_HEIGHT);
    localparam logic [20:0]     BW       = 21'(BURST_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_WORDS - 1);

    fqr_state_t       state_reg, state_next;
    logic [20:0]      row_reg, row_next;
    logic [20:0]      col_reg, col_next;
    logic [IDX_W-1:0] fill_idx_reg, fill_idx_next;
    logic [IDX_W-1:0] beat_reg, beat_next;
    logic             rd_pending_reg;
    logic             done_reg, done_next;
    logic             err_reg, err_next;

    logic             rd_consume;
    logic             buf_we;
    logic [IDX_W-1:0] buf_raddr;
    logic [15:0]      buf_rdata;
    word_kind_t       kind;

    assign kind = classify(queue_data);

    // Reads are only launched when no word is awaiting decode, so the cycle
    // that decodes a word never has a read in flight. This keeps a word from
    // landing while the FSM sits in REQUEST/BURST.
    assign queue_rd_en = rd_consume && !rd_pending_reg && !queue_empty;

    always_comb begin
        state_next    = state_reg;
        row_next      = row_reg;
        col_next      = col_reg;
        fill_idx_next = fill_idx_reg;
        beat_next     = beat_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;
        buf_we        = 1'b0;
        rd_consume    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (mem_ready) state_next = ST_WAIT_FS;
            end

            ST_WAIT_FS: begin
                rd_consume = mem_ready;
                if (rd_pending_reg) begin
                    if (kind == WK_FS) begin
                        row_next      = '0;
                        col_next      = '0;
                        fill_idx_next = '0;
                        state_next    = ST_WAIT_RS;
                    end
                end else if (!mem_ready) begin
                    state_next = ST_IDLE;
                end
            end

            ST_WAIT_RS: begin
                rd_consume = 1'b1;
                if (rd_pending_reg) begin
                    case (kind)
                        WK_RS: begin
                            col_next      = '0;
                            fill_idx_next = '0;
                            state_next    = ST_FILL;
                        end
                        WK_FE: state_next = ST_FRAME_END;
                        WK_FS: begin
                            err_next      = 1'b1;
                            row_next      = '0;
                            col_next      = '0;
                            fill_idx_next = '0;
                        end
                        WK_PIXEL: err_next = 1'b1;
                        default: begin
                            err_next   = 1'b1;
                            state_next = ST_WAIT_FS;
                        end
                    endcase
                end
            end

            ST_FILL: begin
                rd_consume = 1'b1;
                if (rd_pending_reg) begin
                    case (kind)
                        WK_PIXEL: begin
                            buf_we   = 1'b1;
                            col_next = col_reg + 21'd1;
                            if (fill_idx_reg == LAST_IDX) begin
                                fill_idx_next = '0;
                                state_next    = ST_REQUEST;
                            end else begin
                                fill_idx_next = fill_idx_reg + IDX_W'(1);
                            end
                        end
                        // Short row: drop the partial burst, count the row and
                        // treat the RS as the start of the next row.
                        WK_RS: begin
                            err_next      = 1'b1;
                            row_next      = row_reg + 21'd1;
                            col_next      = '0;
                            fill_idx_next = '0;
                        end
                        // Short last row: the error pulse covers the short row
                        // and the frame-end verdict is folded into the same
                        // cycle, so frame_error stays a single pulse.
                        WK_FE: begin
                            err_next      = 1'b1;
                            done_next     = ((row_reg + 21'd1) == FH);
                            fill_idx_next = '0;
                            row_next      = row_reg + 21'd1;
                            state_next    = ST_WAIT_FS;
                        end
                        WK_FS: begin
                            err_next      = 1'b1;
                            row_next      = '0;
                            col_next      = '0;
                            fill_idx_next = '0;
                            state_next    = ST_WAIT_RS;
                        end
                        default: begin
                            err_next      = 1'b1;
                            fill_idx_next = '0;
                            state_next    = ST_WAIT_FS;
                        end
                    endcase
                end
            end

            ST_REQUEST: begin
                if (wr_grant) begin
                    beat_next  = '0;
                    state_next = ST_BURST;
                end
            end

            ST_BURST: begin
                if (beat_reg == LAST_IDX) begin
                    if (col_reg < FW) begin
                        state_next = ST_FILL;
                    end else begin
                        row_next   = row_reg + 21'd1;
                        state_next = ST_WAIT_RS;
                    end
                end else begin
                    beat_next = beat_reg + IDX_W'(1);
                end
            end

            ST_FRAME_END: begin
                if (row_reg == FH) done_next = 1'b1;
                else               err_next  = 1'b1;
                state_next = ST_WAIT_FS;
            end

            default: state_next = ST_IDLE;
        endcase
    end

    // Read address runs one beat ahead of the data: word 0 is fetched while
    // waiting for the grant, word n+1 while beat n is on the bus.
    always_comb begin
        buf_raddr = '0;
        if (state_reg == ST_BURST && beat_reg != LAST_IDX) begin
            buf_raddr = beat_reg + IDX_W'(1);
        end
    end

    always_ff @(posedge MemClk or negedge nRST) begin
        if (!nRST) begin
            state_reg      <= ST_IDLE;
            row_reg        <= '0;
            col_reg        <= '0;
            fill_idx_reg   <= '0;
            beat_reg       <= '0;
            rd_pending_reg <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            row_reg        <= row_next;
            col_reg        <= col_next;
            fill_idx_reg   <= fill_idx_next;
            beat_reg       <= beat_next;
            rd_pending_reg <= queue_rd_en;
            done_reg       <= done_next;
            err_reg        <= err_next;
        end
    end

    frame_queue_reader_burst_buffer #(
        .DEPTH (BURST_WORDS),
        .IDX_W (IDX_W)
    ) u_burst_buffer (
        .clk   (MemClk),
        .we    (buf_we),
        .waddr (fill_idx_reg),
        .wdata (queue_data[15:0]),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    // col_reg already counts the buffered burst, hence the BW back-off.
    assign wr_req        = (state_reg == ST_REQUEST);
    assign wr_addr       = wr_req ? (BASE_ADDR + row_reg * FW + col_reg - BW) : '0;
    assign wr_data_valid = (state_reg == ST_BURST);
    assign wr_data       = wr_data_valid ? buf_rdata : '0;
    assign frame_done    = done_reg;
    assign frame_error   = err_reg;

endmodule

// File: tb/tb_frame_queue_reader.sv
module tb_frame_queue_reader;
    import frame_queue_pkg::*;

    localparam int          FW   = 8;
    localparam int          FH   = 2;
    localparam int          BW   = 4;
    localparam logic [20:0] BASE = 21'h100;

    logic        MemClk = 1'b0;
    logic        nRST = 1'b1;
    logic [16:0] queue_data = '0;
    logic        queue_empty = 1'b1;
    logic        queue_rd_en;
    logic        mem_ready = 1'b0;
    logic        wr_req;
    logic        wr_grant = 1'b0;
    logic [20:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_data_valid;
    logic        frame_done;
    logic        frame_error;

    frame_queue_reader #(
        .FRAME_WIDTH  (FW),
        .FRAME_HEIGHT (FH),
        .BURST_WORDS  (BW),
        .BASE_ADDR    (BASE)
    ) dut (
        .MemClk        (MemClk),
        .nRST          (nRST),
        .queue_data    (queue_data),
        .queue_empty   (queue_empty),
        .queue_rd_en   (queue_rd_en),
        .mem_ready     (mem_ready),
        .wr_req        (wr_req),
        .wr_grant      (wr_grant),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_data_valid (wr_data_valid),
        .frame_done    (frame_done),
        .frame_error   (frame_error)
    );

    always #5 MemClk = ~MemClk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- queue source ----------------
    logic [16:0] src_q[$];
    logic [16:0] stream[$];
    bit          gap_en = 1'b0;

    initial begin
        forever begin
            @(negedge MemClk);
            queue_empty = (src_q.size() == 0) || (gap_en && $urandom_range(0, 2) == 0);
            #4;  // just before the rising edge, rd_en is settled
            if (queue_rd_en) begin
                check_value("rd_while_empty", 32'(queue_empty), 32'd0);
                check_value("rd_without_mem_ready", 32'(mem_ready), 32'd1);
                if (src_q.size() > 0) queue_data = src_q.pop_front();
            end
        end
    end

    // ---------------- write-side monitor / grant ----------------
    logic [20:0] got_addr[$];
    logic [15:0] got_data[$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    bit          prev_req = 1'b0;
    bit          prev_grant = 1'b0;
    logic [20:0] prev_addr = '0;
    int          grant_wait = 0;
    int          max_delay = 0;

    always @(negedge MemClk) begin
        if (!nRST) begin
            wr_grant   = 1'b0;
            prev_req   = 1'b0;
            prev_grant = 1'b0;
        end else begin
            if (wr_data_valid) got_data.push_back(wr_data);
            if (frame_done) done_cnt++;
            if (frame_error) err_cnt++;
            if (prev_grant) check_value("req_drop_after_grant", 32'(wr_req), 32'd0);
            else if (prev_req) check_value("req_hold", {10'd0, wr_req, wr_addr}, {10'd0, 1'b1, prev_addr});
            if (wr_req && !prev_grant) begin
                if (!prev_req) grant_wait = $urandom_range(0, max_delay);
                if (grant_wait == 0) begin
                    wr_grant = 1'b1;
                    got_addr.push_back(wr_addr);
                end else begin
                    grant_wait--;
                    wr_grant = 1'b0;
                end
            end else begin
                wr_grant = 1'b0;
            end
            prev_req   = wr_req;
            prev_grant = wr_grant;
            prev_addr  = wr_addr;
        end
    end

    // ---------------- reference model ----------------
    logic [20:0] exp_addr[$];
    logic [15:0] exp_data[$];
    int          exp_done;
    int          exp_err;

    // Stream-level rules: phase 0 hunts for FS, 1 is between rows, 2 is inside a row.
    task automatic run_model();
        int phase = 0;
        int row = 0;
        int col = 0;
        logic [15:0] pend[$];
        logic [16:0] w;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 0;
        exp_err = 0;
        foreach (stream[i]) begin
            w = stream[i];
            if (phase == 0) begin
                if (w == MARK_FS) begin row = 0; phase = 1; end
            end else if (!w[16]) begin
                if (phase == 1) exp_err++;
                else begin
                    pend.push_back(w[15:0]);
                    col++;
                    if (pend.size() == BW) begin
                        exp_addr.push_back(BASE + 21'(row * FW + col - BW));
                        foreach (pend[j]) exp_data.push_back(pend[j]);
                        pend.delete();
                        if (col == FW) begin row++; phase = 1; end
                    end
                end
            end else if (w == MARK_FS) begin
                exp_err++; row = 0; pend.delete(); phase = 1;
            end else if (w == MARK_RS) begin
                if (phase == 2) begin exp_err++; row++; pend.delete(); end
                col = 0; phase = 2;
            end else if (w == MARK_FE) begin
                if (phase == 2) begin
                    exp_err++; row++; pend.delete();
                    if (row == FH) exp_done++;
                end else if (row == FH) exp_done++;
                else exp_err++;
                phase = 0;
            end else begin
                exp_err++; pend.delete(); phase = 0;
            end
        end
    endtask

    task automatic push_word(input logic [16:0] w);
        src_q.push_back(w);
        stream.push_back(w);
    endtask

    task automatic push_row(input int first, input int n);
        for (int p = 0; p < n; p++) push_word({1'b0, 16'(first + p)});
    endtask

    task automatic push_frame_035();
        push_word(MARK_FS);
        push_word(MARK_RS); push_row(0, 8);
        push_word(MARK_RS); push_row(8, 8);
        push_word(MARK_FE);
    endtask

    task automatic wait_idle(input string name);
        int idle = 0;
        int cyc = 0;
        while (idle < 30 && cyc < 5000) begin
            @(negedge MemClk);
            cyc++;
            if (src_q.size() == 0 && !wr_req && !wr_data_valid) idle++;
            else idle = 0;
        end
        check_value({name, "_drained"}, 32'(idle >= 30), 32'd1);
    endtask

    task automatic compare_scenario(input string name);
        run_model();
        check_value({name, "_nbursts"}, got_addr.size(), exp_addr.size());
        check_value({name, "_nwords"}, got_data.size(), exp_data.size());
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            $display("[TB] %s burst %0d addr=0x%0h", name, i, got_addr[i]);
            check_value({name, "_addr"}, 32'(got_addr[i]), 32'(exp_addr[i]));
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++)
            check_value({name, "_data"}, 32'(got_data[i]), 32'(exp_data[i]));
        check_value({name, "_frame_done"}, done_cnt, exp_done);
        check_value({name, "_frame_error"}, err_cnt, exp_err);
        got_addr.delete();
        got_data.delete();
        stream.delete();
        done_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic check_outputs_zero(input string name);
        check_value({name, "_queue_rd_en"}, 32'(queue_rd_en), 32'd0);
        check_value({name, "_wr_req"}, 32'(wr_req), 32'd0);
        check_value({name, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check_value({name, "_wr_data"}, 32'(wr_data), 32'd0);
        check_value({name, "_wr_data_valid"}, 32'(wr_data_valid), 32'd0);
        check_value({name, "_frame_done"}, 32'(frame_done), 32'd0);
        check_value({name, "_frame_error"}, 32'(frame_error), 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        nRST = 1'b0;
        repeat (2) @(negedge MemClk);
        #1;
        check_outputs_zero("reset");

        // Released, but no reads may happen until mem_ready.
        @(negedge MemClk);
        nRST = 1'b1;
        push_frame_035();
        repeat (6) @(negedge MemClk);
        check_value("no_read_before_mem_ready", src_q.size(), stream.size());
        mem_ready = 1'b1;
        wait_idle("req035");
        compare_scenario("req035");

        // Gaps in the queue and slow grants.
        gap_en = 1'b1;
        max_delay = 10;
        for (int k = 0; k < 3; k++) begin
            push_frame_035();
            wait_idle("req036");
            compare_scenario("req036");
        end

        // Short row followed by a full row.
        push_word(MARK_FS);
        push_word(MARK_RS); push_row(0, 5);
        push_word(MARK_RS); push_row(8, 8);
        push_word(MARK_FE);
        wait_idle("req037");
        compare_scenario("req037");

        // Frame end with too few rows.
        push_word(MARK_FS);
        push_word(MARK_RS); push_row(0, 8);
        push_word(MARK_FE);
        wait_idle("req038");
        compare_scenario("req038");
        check_value("req038_state", 32'(dut.state_reg), 32'(ST_WAIT_FS));

        // Junk ahead of frame start.
        push_row(100, 3);
        push_word(17'h10005);
        push_word(MARK_RS);
        push_word(MARK_FE);
        push_frame_035();
        wait_idle("req039");
        compare_scenario("req039");

        // Randomised frames: junk, variable row count and row lengths.
        for (int s = 0; s < 8; s++) begin
            int nj;
            int nrows;
            int npx;
            nj = $urandom_range(0, 3);
            for (int j = 0; j < nj; j++)
                push_word(($urandom_range(0, 1) == 1) ? 17'h10005 : {1'b0, 16'($urandom)});
            push_word(MARK_FS);
            nrows = $urandom_range(1, 3);
            for (int r = 0; r < nrows; r++) begin
                push_word(MARK_RS);
                npx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, FW) : FW;
                for (int p = 0; p < npx; p++) push_word({1'b0, 16'($urandom)});
            end
            push_word(MARK_FE);
            wait_idle("random");
            compare_scenario("random");
        end

        // Reset on the second burst beat, then a clean frame.
        gap_en = 1'b0;
        max_delay = 0;
        push_frame_035();
        nb = 0;
        for (int c = 0; c < 2000 && nb < 2; c++) begin
            @(negedge MemClk);
            #1;
            if (wr_data_valid) nb++;
        end
        check_value("req040_beat2_reached", nb, 2);
        nRST = 1'b0;
        #1;
        check_outputs_zero("req040_reset");
        src_q.delete();
        repeat (3) @(negedge MemClk);
        #1;
        got_addr.delete();
        got_data.delete();
        stream.delete();
        done_cnt = 0;
        err_cnt = 0;
        @(negedge MemClk);
        nRST = 1'b1;
        push_frame_035();
        wait_idle("req040");
        compare_scenario("req040");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
